// File: rtl/gg_parse_bitwin_pkg.sv
// Shared types and constants for the byte-to-word bit window front end.
package gg_parse_bitwin_pkg;

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} bitwin_state_t;

  localparam logic [7:0]  EPB_BYTE = 8'h03;
  localparam int unsigned EPB_ZRUN = 2;

endpackage

// File: rtl/gg_epb_filter.sv
// Emulation-prevention byte filter: tracks the zero run, decides whether the
// current byte is kept, and flags an illegal byte following a stripped 0x03.
module gg_epb_filter
  import gg_parse_bitwin_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       take,
  input  logic       first,
  input  logic [7:0] data,
  output logic       keep,
  output logic       err
);

  logic [1:0] zcnt_q, zcnt_d, zcnt_eff;
  logic       pend_q, pend_d;
  logic       err_q, err_d;
  logic       drop;

  always_comb begin
    // A first byte starts a fresh NAL, so it sees an empty zero run.
    zcnt_eff = first ? 2'd0 : zcnt_q;
    drop     = (data == EPB_BYTE) && (zcnt_eff == 2'(EPB_ZRUN));
    keep     = !drop;
    zcnt_d   = zcnt_q;
    pend_d   = pend_q;
    err_d    = 1'b0;
    if (take) begin
      err_d  = pend_q && !first && (data > EPB_BYTE);
      pend_d = drop;
      if (data != 8'h00) begin
        zcnt_d = 2'd0;
      end else if (zcnt_eff != 2'(EPB_ZRUN)) begin
        zcnt_d = zcnt_eff + 2'd1;
      end else begin
        zcnt_d = zcnt_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      zcnt_q <= 2'd0;
      pend_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      zcnt_q <= zcnt_d;
      pend_q <= pend_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: rtl/gg_parse_bit_window.sv
// Packs an EPB-stripped NAL byte stream big-endian into WID-bit words, each
// with a 32-bit lookahead, framed by first/last markers.
module gg_parse_bit_window
  import gg_parse_bitwin_pkg::*;
#(
  parameter int unsigned WID = 32
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [7:0]     in_byte,
  input  logic           in_valid,
  input  logic           in_first,
  input  logic           in_last,
  output logic           in_ready,
  output logic [WID-1:0] out_bits,
  output logic [31:0]    out_pad,
  output logic           out_valid,
  input  logic           out_ready,
  output logic           out_first,
  output logic           out_last,
  output logic           ep_err
);

  localparam int unsigned CAP = WID + 40;
  localparam int unsigned CW  = $clog2(CAP + 1);

  localparam logic [CW-1:0] WID_C   = CW'(WID);
  localparam logic [CW-1:0] LIM_IN  = CW'(CAP - 8);
  localparam logic [CW-1:0] LIM_OUT = CW'(WID + 32);
  localparam logic [CW-1:0] BYTE_C  = CW'(8);

  bitwin_state_t  state_q, state_d;
  logic [CAP-1:0] buf_q, buf_d, shifted;
  logic [CW-1:0]  fcnt_q, fcnt_d, base;
  logic           first_q, first_d;
  logic           accept, take, keep, push, pop;

  always_comb begin
    in_ready  = 1'b1;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state_q)
      FILL: begin
        in_ready  = (fcnt_q <= LIM_IN);
        out_valid = (fcnt_q >= LIM_OUT);
      end
      FLUSH: begin
        in_ready  = 1'b0;
        out_valid = (fcnt_q != '0);
        out_last  = (fcnt_q != '0) && (fcnt_q <= WID_C);
      end
      default: ;
    endcase
  end

  assign accept = in_valid & in_ready;
  // Bytes arriving in IDLE without a first marker belong to no NAL.
  assign take   = accept & ((state_q != IDLE) | in_first);
  assign push   = take & keep;
  assign pop    = out_valid & out_ready;

  gg_epb_filter u_epb (
    .clk   (clk),
    .reset (reset),
    .take  (take),
    .first (in_first),
    .data  (in_byte),
    .keep  (keep),
    .err   (ep_err)
  );

  always_comb begin
    shifted = pop ? (buf_q << WID) : buf_q;
    base    = fcnt_q;
    if (pop) begin
      base = (fcnt_q > WID_C) ? (fcnt_q - WID_C) : '0;
    end
    buf_d  = shifted;
    fcnt_d = base;
    if (push) begin
      // Region below the fill level is always zero, so OR-in is enough.
      buf_d  = shifted | ({in_byte, {(CAP-8){1'b0}}} >> base);
      fcnt_d = base + BYTE_C;
    end
    state_d = state_q;
    first_d = pop ? 1'b0 : first_q;
    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = in_last ? FLUSH : FILL;
          first_d = 1'b1;
        end
      end
      FILL: begin
        if (take && in_last) state_d = FLUSH;
      end
      FLUSH: begin
        if ((fcnt_q == '0) || (pop && out_last)) begin
          state_d = IDLE;
          fcnt_d  = '0;
          buf_d   = '0;
          first_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      buf_q   <= '0;
      fcnt_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      fcnt_q  <= fcnt_d;
      first_q <= first_d;
    end
  end

  assign out_bits  = buf_q[CAP-1 -: WID];
  assign out_pad   = buf_q[CAP-1-WID -: 32];
  assign out_first = first_q & out_valid;

endmodule

// File: tb/tb_gg_parse_bit_window.sv
// Self-checking bench for gg_parse_bit_window: directed scenarios plus random
// NALs checked against a byte-level model of EPB stripping and word packing.
module tb_gg_parse_bit_window;

  localparam int unsigned WID = 32;
  localparam int unsigned WB  = WID / 8;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [7:0]     in_byte = '0;
  logic           in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0;
  logic           in_ready;
  logic [WID-1:0] out_bits;
  logic [31:0]    out_pad;
  logic           out_valid, out_first, out_last, ep_err;
  logic           out_ready = 1'b0;

  int errors = 0;
  int checks = 0;
  int ep_pulses;

  logic [WID-1:0] got_bits[$];
  logic [31:0]    got_pad[$];
  logic           got_first[$];
  logic           got_last[$];

  gg_parse_bit_window #(.WID(WID)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_first  (in_first),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_bits  (out_bits),
    .out_pad   (out_pad),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_first (out_first),
    .out_last  (out_last),
    .ep_err    (ep_err)
  );

  always #5 clk = ~clk;

  // Streams one NAL (after `stray` unframed bytes) and checks every popped word
  // and every ep_err pulse against the model built from the byte list.
  task automatic run_nal(input logic [7:0] b[$], input int stray, input int in_pct,
                         input int rdy_pct, input int hold, output int acc_at_hold,
                         output logic rdy_at_hold);
    logic [7:0]     kb[$];
    logic [7:0]     sb[$];
    bit             errf[$];
    int             errq[$];
    logic [WID-1:0] eb[$];
    logic [31:0]    ep[$];
    logic [WID-1:0] w;
    logic [31:0]    p;
    int             z, nw, idx, got, cyc, total, pos;
    bit             pend;
    z = 0; pend = 0; idx = 0; got = 0; cyc = 0;
    foreach (b[i]) begin
      if (i == 0) begin z = 0; pend = 0; end
      if (b[i] == 8'h03 && z == 2) begin
        errf.push_back(1'b0); z = 0; pend = 1;
      end else begin
        errf.push_back(pend && (b[i] > 8'h03));
        pend = 0;
        kb.push_back(b[i]);
        z = (b[i] == 8'h00) ? ((z < 2) ? z + 1 : 2) : 0;
      end
    end
    nw = (kb.size() * 8 + WID - 1) / WID;
    for (int j = 0; j < nw; j++) begin
      w = '0; p = '0;
      for (int k = 0; k < WB; k++) begin
        pos = j * WB + k;
        w = {w[WID-9:0], (pos < kb.size()) ? kb[pos] : 8'h00};
      end
      for (int k = 0; k < 4; k++) begin
        pos = (j + 1) * WB + k;
        p = {p[23:0], (pos < kb.size()) ? kb[pos] : 8'h00};
      end
      eb.push_back(w);
      ep.push_back(p);
    end
    for (int i = 0; i < stray; i++) sb.push_back(8'($urandom_range(255)));
    total = stray + b.size();
    acc_at_hold = 0; rdy_at_hold = 1'b1; ep_pulses = 0;
    got_bits.delete(); got_pad.delete(); got_first.delete(); got_last.delete();

    while ((idx < total || got < nw) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      while (errq.size() != 0 && errq[0] < cyc) begin
        checks++; errors++;
        $display("FAIL ep_err_missing: no pulse at cycle %0d, required 1", errq[0]);
        void'(errq.pop_front());
      end
      if (ep_err) begin
        ep_pulses++;
        checks++;
        if (errq.size() == 0 || errq[0] != cyc) begin
          errors++;
          $display("FAIL ep_err_spurious: pulse at cycle %0d, required none", cyc);
        end
        if (errq.size() != 0 && errq[0] == cyc) void'(errq.pop_front());
      end
      if (cyc == hold) begin
        acc_at_hold = (idx > stray) ? idx - stray : 0;
        rdy_at_hold = in_ready;
      end
      out_ready = (cyc > hold) && (int'($urandom_range(99)) < rdy_pct);
      if (out_valid && out_ready) begin
        got_bits.push_back(out_bits); got_pad.push_back(out_pad);
        got_first.push_back(out_first); got_last.push_back(out_last);
        if (got >= nw) begin
          checks++; errors++;
          $display("FAIL extra_word: got word %0d bits %h, required only %0d words", got, out_bits, nw);
        end else begin
          checks += 4;
          if (out_bits !== eb[got]) begin
            errors++; $display("FAIL word_bits[%0d]: got %h required %h", got, out_bits, eb[got]);
          end
          if (out_pad !== ep[got]) begin
            errors++; $display("FAIL word_pad[%0d]: got %h required %h", got, out_pad, ep[got]);
          end
          if (out_first !== (got == 0)) begin
            errors++; $display("FAIL word_first[%0d]: got %b required %b", got, out_first, got == 0);
          end
          if (out_last !== (got == nw - 1)) begin
            errors++; $display("FAIL word_last[%0d]: got %b required %b", got, out_last, got == nw - 1);
          end
        end
        got++;
      end
      if (idx < total && int'($urandom_range(99)) < in_pct) begin
        in_valid = 1'b1;
        in_byte  = (idx < stray) ? sb[idx] : b[idx - stray];
        in_first = (idx == stray);
        in_last  = (idx == total - 1);
      end else begin
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
      end
      if (in_valid && in_ready) begin
        if (idx >= stray && errf[idx - stray]) errq.push_back(cyc + 1);
        idx++;
      end
    end
    if (cyc >= 4000) begin
      checks++; errors++;
      $display("FAIL timeout: %0d of %0d bytes, %0d of %0d words", idx, total, got, nw);
    end
    @(negedge clk);
    cyc++;
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    if (ep_err) begin
      ep_pulses++;
      checks++;
      if (errq.size() != 0 && errq[0] == cyc) void'(errq.pop_front());
      else begin errors++; $display("FAIL ep_err_spurious: pulse at cycle %0d, required none", cyc); end
    end
    checks += 3;
    if (errq.size() != 0) begin
      errors++; $display("FAIL ep_err_missing: %0d pulses outstanding, required 0", errq.size());
    end
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL idle_in_ready: got %b required 1", in_ready);
    end
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL idle_out_valid: got %b required 0", out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks += 7;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    if (out_first !== 1'b0) begin errors++; $display("FAIL reset_out_first: got %b required 0", out_first); end
    if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b required 0", out_last); end
    if (ep_err !== 1'b0) begin errors++; $display("FAIL reset_ep_err: got %b required 0", ep_err); end
    if (out_bits !== '0) begin errors++; $display("FAIL reset_out_bits: got %h required 0", out_bits); end
    if (out_pad !== '0) begin errors++; $display("FAIL reset_out_pad: got %h required 0", out_pad); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", in_ready); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_plain();
    logic [7:0]  q[$];
    logic [31:0] xb[3];
    logic [31:0] xp[3];
    int          a;
    logic        r;
    q  = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h11};
    xb = '{32'h12345678, 32'h9ABCDEF0, 32'h11000000};
    xp = '{32'h9ABCDEF0, 32'h11000000, 32'h00000000};
    run_nal(q, 0, 100, 100, 0, a, r);
    checks++;
    if (got_bits.size() != 3) begin
      errors++; $display("FAIL plain_count: got %0d required 3", got_bits.size());
    end
    for (int j = 0; j < 3 && j < got_bits.size(); j++) begin
      checks += 2;
      if (got_bits[j] !== xb[j]) begin
        errors++; $display("FAIL plain_bits[%0d]: got %h required %h", j, got_bits[j], xb[j]);
      end
      if (got_pad[j] !== xp[j]) begin
        errors++; $display("FAIL plain_pad[%0d]: got %h required %h", j, got_pad[j], xp[j]);
      end
    end
    if (got_bits.size() == 3) begin
      checks += 2;
      if (got_first[0] !== 1'b1) begin errors++; $display("FAIL plain_first: got %b required 1", got_first[0]); end
      if (got_last[2] !== 1'b1) begin errors++; $display("FAIL plain_last: got %b required 1", got_last[2]); end
    end
  endtask

  task automatic test_epb_strip();
    logic [7:0] q[$];
    int         a;
    logic       r;
    q = '{8'h00, 8'h00, 8'h03, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_nal(q, 0, 100, 100, 0, a, r);
    checks += 3;
    if (got_bits.size() != 2) begin errors++; $display("FAIL strip_count: got %0d required 2", got_bits.size()); end
    if (got_bits.size() == 0 || got_bits[0] !== 32'h000001AA) begin
      errors++; $display("FAIL strip_word0: got %h required 000001aa", got_bits.size() ? got_bits[0] : 'x);
    end
    if (ep_pulses != 0) begin errors++; $display("FAIL strip_ep_err: got %0d pulses required 0", ep_pulses); end
  endtask

  task automatic test_epb_err();
    logic [7:0] q[$];
    int         a;
    logic       r;
    q = '{8'h00, 8'h00, 8'h03, 8'h07};
    run_nal(q, 0, 100, 100, 0, a, r);
    checks += 3;
    if (got_bits.size() != 1) begin errors++; $display("FAIL eperr_count: got %0d required 1", got_bits.size()); end
    if (got_bits.size() == 0 || got_bits[0] !== 32'h00000700 || got_last[0] !== 1'b1) begin
      errors++; $display("FAIL eperr_word: got %h required 00000700 with last", got_bits.size() ? got_bits[0] : 'x);
    end
    if (ep_pulses != 1) begin errors++; $display("FAIL eperr_pulses: got %0d required 1", ep_pulses); end
  endtask

  task automatic test_backpressure();
    logic [7:0] q[$];
    int         a;
    logic       r;
    for (int i = 1; i <= 12; i++) q.push_back(8'(i));
    run_nal(q, 0, 100, 100, 20, a, r);
    checks += 4;
    if (a != 9) begin errors++; $display("FAIL bp_accepts: got %0d required 9", a); end
    if (r !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b required 0", r); end
    if (got_bits.size() != 3) begin errors++; $display("FAIL bp_count: got %0d required 3", got_bits.size()); end
    if (got_bits.size() < 3 || got_bits[2] !== 32'h090A0B0C) begin
      errors++; $display("FAIL bp_word2: got %h required 090a0b0c", got_bits.size() > 2 ? got_bits[2] : 'x);
    end
  endtask

  task automatic test_dropped_tail();
    logic [7:0] q[$];
    int         a;
    logic       r;
    q = '{8'h00, 8'h00, 8'h03};
    run_nal(q, 0, 100, 100, 0, a, r);
    checks += 2;
    if (got_bits.size() != 1) begin errors++; $display("FAIL tail_count: got %0d required 1", got_bits.size()); end
    if (got_bits.size() == 0 || got_bits[0] !== '0 || got_last[0] !== 1'b1) begin
      errors++; $display("FAIL tail_word: got %h required 00000000 with last", got_bits.size() ? got_bits[0] : 'x);
    end
  endtask

  task automatic test_reset_mid_flush();
    logic [7:0] q[$];
    int         a;
    logic       r;
    out_ready = 1'b0;
    q = '{8'h11, 8'h22, 8'h33, 8'h44};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_byte = q[i]; in_first = (i == 0); in_last = (i == 3);
    end
    @(negedge clk);
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b required 1", out_valid); end
    reset = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0 || out_first !== 1'b0 || out_last !== 1'b0 || ep_err !== 1'b0) begin
      errors++; $display("FAIL rst_flags: got v%b f%b l%b e%b required all 0", out_valid, out_first, out_last, ep_err);
    end
    if (out_bits !== '0 || out_pad !== '0) begin
      errors++; $display("FAIL rst_data: got %h/%h required 0/0", out_bits, out_pad);
    end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready: got %b required 1", in_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    q = '{8'hAB, 8'hCD, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
    run_nal(q, 0, 100, 100, 0, a, r);
    checks += 2;
    if (got_bits.size() != 2) begin errors++; $display("FAIL rst_next_count: got %0d required 2", got_bits.size()); end
    if (got_bits.size() == 0 || got_bits[0] !== 32'hABCDEF01 || got_first[0] !== 1'b1) begin
      errors++; $display("FAIL rst_next_word: got %h required abcdef01 with first", got_bits.size() ? got_bits[0] : 'x);
    end
  endtask

  task automatic test_random();
    logic [7:0] q[$];
    int         len, rr, a;
    logic       r;
    for (int n = 0; n < 30; n++) begin
      q.delete();
      len = int'($urandom_range(20, 1));
      for (int i = 0; i < len; i++) begin
        rr = int'($urandom_range(9));
        q.push_back((rr < 4) ? 8'h00 : (rr < 6) ? 8'h03 : 8'($urandom_range(255)));
      end
      run_nal(q, int'($urandom_range(2)), 70, 60, 0, a, r);
    end
  endtask

  initial begin
    test_reset();
    test_plain();
    test_epb_strip();
    test_epb_err();
    test_backpressure();
    test_dropped_tail();
    test_reset_mid_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gg_parse_bit_window.md
# gg_parse_bit_window

Byte-to-word front end for the macroblock/transform-block parse lattice. It accepts a NAL payload as a byte stream with valid/ready handshake and strips H.264 emulation-prevention bytes (0x00 0x00 0x03). It packs the result big-endian into WID-bit words, each presented with a 32-bit lookahead `out_pad`, which is exactly the `in_bits`/`in_pad` pair the lattice consumes. A first/last marker frames each NAL so the downstream controller can place `mb_start`.

## Interface
- `WID`, 32: output word width in bits; multiple of 8, 32..128.
- `CAP`, WID+40: internal buffer capacity in bits (localparam, not overridable).
- `clk` in 1: single clock, all flops rising-edge.
- `reset` in 1: asynchronous, active-low (low = reset).
- `in_byte` in 8: payload byte, first-in byte goes to the MSBs of the output.
- `in_valid` in 1: `in_byte` valid.
- `in_first` in 1: `in_byte` is the first payload byte of a NAL.
- `in_last` in 1: `in_byte` is the final payload byte of a NAL.
- `in_ready` out 1: byte accepted when `in_valid & in_ready`.
- `out_bits` out WID: bitstream word; `out_bits[WID-1]` is the earliest bit.
- `out_pad` out 32: the 32 bits following `out_bits[0]`, zero beyond end of NAL.
- `out_valid` out 1: word valid.
- `out_ready` in 1: word consumed when `out_valid & out_ready`.
- `out_first` out 1: word is the first of its NAL.
- `out_last` out 1: word holds the final payload bits (zero-filled tail).
- `ep_err` out 1: one-cycle pulse; byte after a stripped 0x03 exceeded 0x03.

## Operation
- Buffer `buf[CAP-1:0]` is left-aligned, and `fcnt` (bits, multiple of 8, width $clog2(CAP+1)) holds the valid-bit count. `out_bits = buf[CAP-1 -: WID]` and `out_pad = buf[CAP-1-WID -: 32]`, both driven directly from flops.
- States:
  - IDLE: `fcnt`=0; `in_ready`=1. An accepted byte with `in_first` goes to FILL. An accepted byte without `in_first` is discarded.
  - FILL: `in_ready = (fcnt <= CAP-8)`. `out_valid = (fcnt >= WID+32)`. An accepted `in_last` goes to FLUSH.
  - FLUSH: `in_ready`=0. `out_valid = (fcnt != 0)`. `out_last = (fcnt <= WID)`. A pop with `out_last` goes to IDLE with `fcnt`=0.
- Push appends the byte at bit position `CAP-1-fcnt` and adds 8 to `fcnt`. Pop shifts `buf` left by WID, zero-fills, and subtracts WID from `fcnt`, saturating at 0. Push and pop in the same cycle are both applied: the byte lands at `CAP-1-(fcnt-WID)`.
- Emulation prevention:
  - `zcnt` counts consecutive accepted 0x00 bytes, saturates at 2, and clears on `in_first`.
  - An accepted 0x03 with `zcnt`=2 is dropped. It completes the handshake but does not push, and it sets `zcnt`=0.
  - The next accepted byte, if greater than 0x03, pulses `ep_err` the following cycle and is still pushed.
- A dropped 0x03 carrying `in_last` still moves the block to FLUSH.
- `out_first` is set on the first word after FILL entry and clears on that word's pop.
- A NAL shorter than WID+32 bits is emitted entirely in FLUSH, zero-padded.

## Timing
- Reset values: `buf`=0, `fcnt`=0, `zcnt`=0, state IDLE. Outputs: `out_valid`/`out_first`/`out_last`/`ep_err`=0, `out_bits`/`out_pad`=0, `in_ready`=1 (combinational from state/fcnt).
- Latency: `out_valid` rises the cycle after the accept that brings `fcnt` to ≥ WID+32, or after the `in_last` accept if that comes first.
- With WID=32 and no backpressure, the first word is valid 1 cycle after the 8th stored byte.
- Throughput: 1 byte/cycle in, so one word per WID/8 cycles.
- `out_*` hold stable while `out_valid & !out_ready`.
- A reset assertion mid-NAL clears everything immediately; nothing partial is emitted after release.

## Structure
- `gg_parse_bitwin_pkg` holds:
  - state enum `bitwin_state_t` {IDLE, FILL, FLUSH};
  - constants `EPB_BYTE`=8'h03 and `EPB_ZRUN`=2.
- Sub-module `gg_epb_filter` holds the `zcnt` flops, the drop decision, and `ep_err` generation. Per byte it returns `keep` and `err`, purely combinational except `zcnt`/`err`.
- Top level holds the FSM, buffer, and counter.

## Test plan
- Plain NAL, WID=32: bytes 12 34 56 78 9A BC DE F0 11 (first on 12, last on 11) should produce three words:
  - bits 0x12345678, pad 0x9ABCDEF0, first=1;
  - bits 0x9ABCDEF0, pad 0x11000000;
  - bits 0x11000000, pad 0, last=1.
- EPB strip: 00 00 03 01 AA BB CC DD EE (last) → first word 0x000001AA, `ep_err` never asserts, 8 bytes stored.
- EPB error: 00 00 03 07 (last) → single word 0x00000700, last=1, `ep_err` one-cycle pulse after the 07 accept.
- Backpressure: `out_ready`=0 while streaming 12 bytes → `in_ready` drops after the 9th accept (`fcnt`=72). Releasing `out_ready` then drains in order with no loss or duplication.
- Dropped tail: 00 00 03 with `in_last` on the 03 → one word 0x00000000 (16 data bits), last=1, then return to IDLE.
- Reset mid-FLUSH: assert `reset` low for 2 cycles while `out_valid`=1 → all outputs 0 and `in_ready`=1. The next NAL's first word is correct with `out_first`=1.
